// File: rtl/output_file.sv
// Output FIFO between the CPU and a consumer: show-ahead read port, sticky
// overflow on dropped writes and a saturating count of accepted words.
module output_file #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write,
  input  logic [WIDTH-1:0]         data,
  input  logic                     flush,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              word_count,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head_q;
  logic [AW-1:0]    tail_q;
  logic [AW:0]      count_q;
  logic [15:0]      word_count_q;
  logic             overflow_q;

  logic pop;
  logic push;
  logic drop;

  // Status flags come from the registered occupancy only.
  assign out_valid  = (count_q != '0);
  assign full       = (count_q == FULL_COUNT);
  assign count      = count_q;
  assign out_data   = mem[head_q];
  assign word_count = word_count_q;
  assign overflow   = overflow_q;

  always_comb begin
    pop  = 1'b0;
    push = 1'b0;
    drop = 1'b0;
    if (!flush) begin
      pop  = out_valid & out_ready;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      push = write & (~full | pop);
      drop = write & full & ~pop;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop) begin
        head_q <= head_q + 1'b1;
      end
      if (push) begin
        tail_q <= tail_q + 1'b1;
        if (word_count_q != '1) begin
          word_count_q <= word_count_q + 16'd1;
        end
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail_q] <= data;
    end
  end

endmodule

// File: tb/tb_output_file.sv
// Randomised and directed checks of output_file against a queue-based model.
module tb_output_file;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             write;
  logic [WIDTH-1:0] data;
  logic             flush;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             full;
  logic [4:0]       count;
  logic [15:0]      word_count;
  logic             overflow;

  output_file #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .write(write), .data(data), .flush(flush),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .full(full), .count(count), .word_count(word_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] mq[$];
  int unsigned      m_wc;
  bit               m_ov;
  bit               per_cycle = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(mq.size() != 0));
    chk({tag, ".count"}, 32'(count), 32'(mq.size()));
    chk({tag, ".full"}, 32'(full), 32'(mq.size() == DEPTH));
    chk({tag, ".wc"}, 32'(word_count), m_wc);
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ov));
    if (mq.size() != 0) chk({tag, ".data"}, 32'(out_data), 32'(mq[0]));
  endtask

  // Called at a negedge: drive inputs, advance model at posedge, check at next negedge.
  task automatic step(input string tag, input bit w, input logic [WIDTH-1:0] d,
                      input bit f, input bit r);
    bit do_pop, do_push;
    write = w; data = d; flush = f; out_ready = r;
    @(posedge clk);
    do_pop  = !f && r && mq.size() != 0;
    do_push = !f && w && (mq.size() < DEPTH || do_pop);
    if (f) mq.delete();
    else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(d);
        if (m_wc < 32'hFFFF) m_wc++;
      end
      if (w && !do_push) m_ov = 1'b1;
    end
    @(negedge clk);
    if (per_cycle) check_state(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    write = 1'b0; flush = 1'b0; out_ready = 1'b0; data = '0;
    @(posedge clk);
    mq.delete(); m_wc = 0; m_ov = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; write = 1'b0; data = '0; flush = 1'b0; out_ready = 1'b0;
    mq.delete(); m_wc = 0; m_ov = 1'b0;
    #2;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.full", 32'(full), 32'd0);
    chk("rst.wc", 32'(word_count), 32'd0);
    chk("rst.ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Three words then drain.
    for (int i = 1; i <= 3; i++) step("basic.wr", 1, 16'(i), 0, 0);
    chk("basic.count3", 32'(count), 32'd3);
    chk("basic.head", 32'(out_data), 32'h0001);
    for (int i = 0; i < 3; i++) step("basic.rd", 0, '0, 0, 1);
    chk("basic.empty", 32'(out_valid), 32'd0);
    chk("basic.wc3", 32'(word_count), 32'd3);

    // Fill, overflow, drain.
    do_reset();
    for (int i = 0; i < 16; i++) step("fill.wr", 1, 16'(16'h100 + i), 0, 0);
    step("fill.drop", 1, 16'hDEAD, 0, 0);
    chk("fill.full", 32'(full), 32'd1);
    chk("fill.ovf", 32'(overflow), 32'd1);
    chk("fill.wc16", 32'(word_count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("fill.order", 32'(out_data), 32'(16'h100 + i));
      step("fill.rd", 0, '0, 0, 1);
    end
    chk("fill.empty", 32'(out_valid), 32'd0);

    // Push and pop together while full.
    do_reset();
    for (int i = 0; i < 16; i++) step("fp.wr", 1, 16'(16'h200 + i), 0, 0);
    step("fp.both", 1, 16'hBEEF, 0, 1);
    chk("fp.count", 32'(count), 32'd16);
    chk("fp.ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 15; i++) step("fp.rd", 0, '0, 0, 1);
    chk("fp.last", 32'(out_data), 32'hBEEF);
    step("fp.rd", 0, '0, 0, 1);

    // Push and pop together while empty.
    step("ep.both", 1, 16'h0055, 0, 1);
    chk("ep.count", 32'(count), 32'd1);

    // Flush beats write.
    do_reset();
    for (int i = 0; i < 5; i++) step("fl.wr", 1, 16'(16'h300 + i), 0, 0);
    step("fl.flush", 1, 16'h00AA, 1, 1);
    chk("fl.count", 32'(count), 32'd0);
    chk("fl.valid", 32'(out_valid), 32'd0);
    chk("fl.wc", 32'(word_count), 32'd5);
    for (int i = 0; i < 3; i++) step("fl.after", 0, '0, 0, 1);

    // Random traffic across wrap-around, with an asynchronous reset mid-stream.
    do_reset();
    for (int i = 0; i < 40; i++)
      step("rnd", ($urandom_range(3) != 0), 16'($urandom), 0, 1'($urandom_range(1)));
    #2;
    reset = 1'b1;
    #1;
    chk("arst.valid", 32'(out_valid), 32'd0);
    chk("arst.count", 32'(count), 32'd0);
    chk("arst.full", 32'(full), 32'd0);
    chk("arst.wc", 32'(word_count), 32'd0);
    chk("arst.ovf", 32'(overflow), 32'd0);
    mq.delete(); m_wc = 0; m_ov = 1'b0;
    write = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step("arst.first", 1, 16'h4242, 0, 0);
    chk("arst.firstcnt", 32'(count), 32'd1);
    for (int i = 0; i < 60; i++)
      step("rnd2", 1'($urandom_range(1)), 16'($urandom), ($urandom_range(19) == 0),
           1'($urandom_range(1)));

    // Saturating word counter.
    do_reset();
    per_cycle = 1'b0;
    for (int i = 0; i < 65534; i++) step("sat.stream", 1, 16'(i), 0, 1);
    per_cycle = 1'b1;
    chk("sat.fffe", 32'(word_count), 32'hFFFE);
    for (int i = 0; i < 3; i++) step("sat.wr", 1, 16'(16'h500 + i), 0, 0);
    chk("sat.ffff", 32'(word_count), 32'hFFFF);
    step("sat.hold", 1, 16'h0600, 0, 1);
    chk("sat.hold", 32'(word_count), 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
